// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice.
//   - default widths for data, register index and producer tag
//   - ZERO_REG: index of the hardwired-zero register
//   - slice_vec(): pulls field idx (width w) out of a packed multi-port bus
package regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int TAG_W_DEF   = 4;
  localparam int ZERO_REG    = 0;

  // Widest packed port bus slice_vec() can take apart.
  localparam int SLICE_MAX_W = 1024;

  // Callers widen the bus to SLICE_MAX_W and size-cast the result back to
  // the field width, so the function itself stays width-agnostic.
  function automatic logic [SLICE_MAX_W-1:0] slice_vec(
    input logic [SLICE_MAX_W-1:0] vec,
    input int unsigned            idx,
    input int unsigned            w
  );
    logic [SLICE_MAX_W-1:0] mask;
    mask = (SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1);
    return (vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy/tag scoreboard for the register file.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rdy                 global enable; state holds when low
//   we/waddr/wtag       writeback ports; a matching tag clears busy
//   alloc_en/addr/tag   marks one destination busy with a producer tag
//   flush               clears every busy bit
//   raddr               per-read-port lookup index
//   rd_busy/rd_tag      registered busy/tag at raddr
// Update priority on one index: flush > alloc > writeback clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [NUM_WR-1:0] we,
  input  logic [ADDR_W-1:0] waddr [NUM_WR],
  input  logic [TAG_W-1:0]  wtag [NUM_WR],
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic              flush,
  input  logic [ADDR_W-1:0] raddr [NUM_RD],
  output logic [NUM_RD-1:0] rd_busy,
  output logic [TAG_W-1:0]  rd_tag [NUM_RD]
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [TAG_W-1:0]    tag     [NUM_REGS];
  logic [TAG_W-1:0]    tag_nxt [NUM_REGS];

  // Clears compare against the registered tag, so an alloc landing in the
  // same cycle is never cleared by that cycle's writeback.
  always_comb begin
    busy_nxt = busy;
    tag_nxt  = tag;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && busy[waddr[k]] && (tag[waddr[k]] == wtag[k])) begin
        busy_nxt[waddr[k]] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != ZERO_IDX) && !flush) begin
      busy_nxt[alloc_addr] = 1'b1;
      tag_nxt[alloc_addr]  = alloc_tag;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        tag[i] <= '0;
      end
    end else if (rdy) begin
      busy <= busy_nxt;
      for (int i = 0; i < NUM_REGS; i++) begin
        tag[i] <= tag_nxt[i];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_lookup
    assign rd_busy[j] = busy[raddr[j]];
    assign rd_tag[j]  = tag[raddr[j]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with busy/tag scoreboard.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rdy                   global enable; low freezes state and disables bypass
//   we/waddr/wdata/wtag   NUM_WR write/writeback ports, packed per port
//   re/raddr              NUM_RD read ports, packed per port
//   rdata/rbusy/rtag      combinational read results
//   alloc_en/addr/tag     destination allocation (visible next cycle)
//   flush                 clear all busy bits
// Register 0 reads as zero and is never busy. On index conflicts the
// highest-numbered write port wins.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR*TAG_W-1:0]  wtag,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [NUM_RD*TAG_W-1:0]  rtag,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic                     flush
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [TAG_W-1:0]  wt [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign wa[k] = ADDR_W'(slice_vec(SLICE_MAX_W'(waddr), k, ADDR_W));
    assign wd[k] = DATA_W'(slice_vec(SLICE_MAX_W'(wdata), k, DATA_W));
    assign wt[k] = TAG_W'(slice_vec(SLICE_MAX_W'(wtag), k, TAG_W));
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_unpack
    assign ra[j] = ADDR_W'(slice_vec(SLICE_MAX_W'(raddr), j, ADDR_W));
  end

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Ascending port order: the last non-blocking write (highest k) wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rdy) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && (wa[k] != ZERO_IDX)) begin
          regs[wa[k]] <= wd[k];
        end
      end
    end
  end

  logic [NUM_RD-1:0] sb_busy;
  logic [TAG_W-1:0]  sb_tag [NUM_RD];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .we         (we),
    .waddr      (wa),
    .wtag       (wt),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_tag  (alloc_tag),
    .flush      (flush),
    .raddr      (ra),
    .rd_busy    (sb_busy),
    .rd_tag     (sb_tag)
  );

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [DATA_W-1:0] d;
    logic              b;
    logic [TAG_W-1:0]  t;

    // Forwarded busy follows the forwarding port's tag only; the stored tag
    // is still reported so a stale writeback shows who is outstanding.
    always_comb begin
      d = '0;
      b = 1'b0;
      t = '0;
      if (re[j] && rst_n && (ra[j] != ZERO_IDX)) begin
        d = regs[ra[j]];
        b = sb_busy[j];
        t = sb_tag[j];
        if ((BYPASS != 0) && rdy) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (we[k] && (wa[k] == ra[j])) begin
              d = wd[k];
              b = (wt[k] == sb_tag[j]) ? 1'b0 : sb_busy[j];
            end
          end
        end
      end
    end

    assign rdata[j*DATA_W +: DATA_W] = d;
    assign rbusy[j]                  = b;
    assign rtag[j*TAG_W +: TAG_W]    = t;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int TW = 4;
  localparam int NREGS = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rdy = 1'b1;
  logic [NW-1:0]  we = '0;
  logic [NW*AW-1:0] waddr = '0;
  logic [NW*DW-1:0] wdata = '0;
  logic [NW*TW-1:0] wtag = '0;
  logic [NR-1:0]  re = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rbusy;
  logic [NR*TW-1:0] rtag;
  logic           alloc_en = 1'b0;
  logic [AW-1:0]  alloc_addr = '0;
  logic [TW-1:0]  alloc_tag = '0;
  logic           flush = 1'b0;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .NUM_WR (NW), .TAG_W (TW), .BYPASS (1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .rdy (rdy),
    .we (we), .waddr (waddr), .wdata (wdata), .wtag (wtag),
    .re (re), .raddr (raddr), .rdata (rdata), .rbusy (rbusy), .rtag (rtag),
    .alloc_en (alloc_en), .alloc_addr (alloc_addr), .alloc_tag (alloc_tag),
    .flush (flush)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: architectural state ----------------
  logic [DW-1:0] m_regs [NREGS];
  logic          m_busy [NREGS];
  logic [TW-1:0] m_tag  [NREGS];

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic model_step();
    logic          nb [NREGS];
    logic [TW-1:0] nt [NREGS];
    int a;
    for (int i = 0; i < NREGS; i++) begin
      nb[i] = m_busy[i];
      nt[i] = m_tag[i];
    end
    for (int k = 0; k < NW; k++) begin
      if (we[k]) begin
        a = int'(waddr[k*AW +: AW]);
        if (m_busy[a] && (m_tag[a] == wtag[k*TW +: TW])) nb[a] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != 0) && !flush) begin
      nb[alloc_addr] = 1'b1;
      nt[alloc_addr] = alloc_tag;
    end
    if (flush) begin
      for (int i = 0; i < NREGS; i++) nb[i] = 1'b0;
    end
    for (int k = 0; k < NW; k++) begin
      a = int'(waddr[k*AW +: AW]);
      if (we[k] && (a != 0)) m_regs[a] = wdata[k*DW +: DW];
    end
    for (int i = 0; i < NREGS; i++) begin
      m_busy[i] = nb[i];
      m_tag[i]  = nt[i];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (rdy) model_step();
  end

  // Expected read result for port j from the model plus current inputs.
  function automatic void exp_read(input int j, output logic [31:0] d,
                                   output logic b, output logic [3:0] t);
    int a;
    d = '0;
    b = 1'b0;
    t = '0;
    a = int'(raddr[j*AW +: AW]);
    if (!re[j] || !rst_n || (a == 0)) return;
    d = m_regs[a];
    b = m_busy[a];
    t = m_tag[a];
    if (rdy) begin
      for (int k = NW - 1; k >= 0; k--) begin
        if (we[k] && (int'(waddr[k*AW +: AW]) == a)) begin
          d = wdata[k*DW +: DW];
          b = (wtag[k*TW +: TW] == m_tag[a]) ? 1'b0 : m_busy[a];
          return;
        end
      end
    end
  endfunction

  // ---------------- compare process (mid-cycle) ----------------
  logic [31:0] ed;
  logic        eb;
  logic [3:0]  et;
  bit          cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int j = 0; j < NR; j++) begin
        exp_read(j, ed, eb, et);
        check($sformatf("model_rdata%0d", j), rdata[j*DW +: DW], ed);
        check($sformatf("model_rbusy%0d", j), 32'(rbusy[j]), 32'(eb));
        if (eb) check($sformatf("model_rtag%0d", j), 32'(rtag[j*TW +: TW]), 32'(et));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1;
    we = '0;
    waddr = '0;
    wdata = '0;
    wtag = '0;
    re = '0;
    raddr = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    alloc_tag = '0;
    flush = 1'b0;
  endtask

  task automatic wr(input int k, input int a, input logic [31:0] d, input int t);
    we[k] = 1'b1;
    waddr[k*AW +: AW] = AW'(a);
    wdata[k*DW +: DW] = d;
    wtag[k*TW +: TW]  = TW'(t);
  endtask

  task automatic rd(input int j, input int a);
    re[j] = 1'b1;
    raddr[j*AW +: AW] = AW'(a);
  endtask

  task automatic alloc(input int a, input int t);
    alloc_en = 1'b1;
    alloc_addr = AW'(a);
    alloc_tag = TW'(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle();
    rst_n = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    repeat (3) cyc();
    idle(); rd(0, 5); rd(1, 3);
    #2;
    check("reset_rdata", rdata[0 +: DW], 32'h0);
    check("reset_rbusy", 32'(rbusy[0]), 32'h0);

    // Reset asserted while a write of x5 is pending
    cyc(); rst_n = 1'b1; idle();
    cyc(); idle(); wr(0, 5, 32'hDEADBEEF, 0); rd(1, 5);
    #1; rst_n = 1'b0;
    cyc(); rst_n = 1'b1; idle(); rd(0, 5);
    #2;
    check("rst_midwrite_rdata", rdata[0 +: DW], 32'h0);
    check("rst_midwrite_rbusy", 32'(rbusy[0]), 32'h0);

    // Alloc then matching writeback
    cyc(); idle(); alloc(3, 7);
    cyc(); idle(); rd(0, 3);
    #2;
    check("alloc_rbusy", 32'(rbusy[0]), 32'h1);
    check("alloc_rtag", 32'(rtag[0 +: TW]), 32'h7);
    cyc(); idle(); wr(0, 3, 32'h1234, 7); rd(0, 3);
    #2;
    check("wb_bypass_rdata", rdata[0 +: DW], 32'h1234);
    check("wb_bypass_rbusy", 32'(rbusy[0]), 32'h0);
    cyc(); idle(); rd(0, 3);
    #2;
    check("wb_state_rdata", rdata[0 +: DW], 32'h1234);
    check("wb_state_rbusy", 32'(rbusy[0]), 32'h0);

    // Stale writeback
    cyc(); idle(); alloc(3, 7);
    cyc(); idle(); wr(1, 3, 32'h55, 2); rd(1, 3);
    #2;
    check("stale_rdata", rdata[DW +: DW], 32'h55);
    check("stale_rbusy", 32'(rbusy[1]), 32'h1);
    check("stale_rtag", 32'(rtag[TW +: TW]), 32'h7);
    cyc(); idle(); rd(1, 3);
    #2;
    check("stale_state_rdata", rdata[DW +: DW], 32'h55);
    check("stale_state_rbusy", 32'(rbusy[1]), 32'h1);

    // Write-port conflict
    cyc(); idle(); wr(0, 9, 32'hAAAA, 0); wr(1, 9, 32'hBBBB, 0); rd(1, 9);
    #2;
    check("conflict_bypass", rdata[DW +: DW], 32'hBBBB);
    cyc(); idle(); rd(1, 9);
    #2;
    check("conflict_state", rdata[DW +: DW], 32'hBBBB);

    // Flush beats same-cycle alloc
    cyc(); idle(); alloc(6, 1);
    cyc(); idle(); flush = 1'b1; alloc(4, 3); rd(0, 6);
    #2;
    check("preflush_x6_busy", 32'(rbusy[0]), 32'h1);
    cyc(); idle(); rd(0, 4); rd(1, 6);
    #2;
    check("flush_x4_busy", 32'(rbusy[0]), 32'h0);
    check("flush_x6_busy", 32'(rbusy[1]), 32'h0);

    // Register 0
    cyc(); idle(); alloc(0, 5); wr(0, 0, 32'hFFFF, 5); rd(0, 0);
    #2;
    check("x0_bypass_rdata", rdata[0 +: DW], 32'h0);
    check("x0_bypass_rbusy", 32'(rbusy[0]), 32'h0);
    cyc(); idle(); rd(0, 0);
    #2;
    check("x0_state_rdata", rdata[0 +: DW], 32'h0);
    check("x0_state_rbusy", 32'(rbusy[0]), 32'h0);

    // rdy=0 freezes state and disables bypass
    cyc(); idle(); wr(0, 7, 32'h11, 0);
    cyc(); idle(); rdy = 1'b0; wr(0, 7, 32'h77, 0); rd(0, 7);
    #2;
    check("rdy0_no_bypass", rdata[0 +: DW], 32'h11);
    cyc(); idle(); rd(0, 7);
    #2;
    check("rdy0_no_write", rdata[0 +: DW], 32'h11);

    // Randomized traffic on a narrow index range to force hits and conflicts
    for (int n = 0; n < 3000; n++) begin
      cyc();
      idle();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      rdy = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 1) == 1)
          wr(k, int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)));
      end
      for (int j = 0; j < NR; j++) begin
        re[j] = ($urandom_range(0, 5) != 0);
        raddr[j*AW +: AW] = AW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0)
        alloc(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 29) == 0);
    end

    cyc();
    rst_n = 1'b1;
    idle();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
